iq_free_list: RTL

Allocator for issue-queue entry IDs.
- Supplies one free IQ entry ID per dispatch lane to the IQ partitions.
- Reclaims the IDs of entries granted by the select logic.
- Sits between dispatch and the IQ. It is the producer of the free-entry packets and the consumer of the selected-entry packets that the IQ partitions use.
- Implemented as a circular FIFO of free IDs with multi-pop and multi-push per cycle.

---
 rtl/iq_free_list.sv | 133 +++++++++++++
 1 files changed

// File: rtl/iq_free_list.sv
// Issue-queue entry-ID allocator: circular FIFO of free IDs.
// Up to DISPATCH_WIDTH pops and ISSUE_WIDTH pushes can happen in one cycle.

module iq_free_list_push_lane #(
   parameter int SIZE_ISSUEQ_LOG = 5,
   parameter int ISSUE_WIDTH     = 4,
   parameter int LANE            = 0
) (
   input  logic [SIZE_ISSUEQ_LOG-1:0] tailPtr,
   input  logic [ISSUE_WIDTH-1:0]     selValid,
   input  logic                       dropAll,
   output logic                       wrEn,
   output logic [SIZE_ISSUEQ_LOG-1:0] wrAddr
);
   localparam logic [ISSUE_WIDTH-1:0] LOWER_MASK = ISSUE_WIDTH'((1 << LANE) - 1);

   logic [ISSUE_WIDTH-1:0]     lowerValid;
   logic [SIZE_ISSUEQ_LOG-1:0] offset;

   // A lane's slot is the number of valid lanes below it, which compacts the grants.
   always_comb begin
      lowerValid = selValid & LOWER_MASK;
      offset     = '0;
      for (int j = 0; j < ISSUE_WIDTH; j++)
         offset = offset + SIZE_ISSUEQ_LOG'(lowerValid[j]);
      wrEn   = selValid[LANE] & ~dropAll;
      wrAddr = tailPtr + offset;
   end
endmodule

module iq_free_list #(
   parameter int SIZE_ISSUEQ     = 32,
   parameter int SIZE_ISSUEQ_LOG = 5,
   parameter int DISPATCH_WIDTH  = 4,
   parameter int ISSUE_WIDTH     = 4
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      flush_i,
   input  logic [DISPATCH_WIDTH-1:0]                 dispatchLaneActive_i,
   input  logic                                      dispatchReady_i,
   input  logic [ISSUE_WIDTH-1:0]                    selValid_i,
   input  logic [ISSUE_WIDTH*SIZE_ISSUEQ_LOG-1:0]    selId_i,
   output logic [DISPATCH_WIDTH*SIZE_ISSUEQ_LOG-1:0] freeId_o,
   output logic [DISPATCH_WIDTH-1:0]                 freeValid_o,
   output logic [SIZE_ISSUEQ_LOG:0]                  freeCnt_o,
   output logic                                      iqStall_o,
   output logic                                      error_o
);
   localparam int LOG = SIZE_ISSUEQ_LOG;
   localparam int CW  = SIZE_ISSUEQ_LOG + 1;

   logic [LOG-1:0] idBuf [SIZE_ISSUEQ];
   logic [LOG-1:0] headPtr, tailPtr;
   logic [CW-1:0]  freeCnt;

   logic [CW-1:0]  activeCnt, popN, pushN;
   logic [CW:0]    cntSum;
   logic           stall, underflow, overflow;

   logic [ISSUE_WIDTH-1:0]          wrEn;
   logic [ISSUE_WIDTH-1:0][LOG-1:0] wrAddr;
   logic [ISSUE_WIDTH-1:0][LOG-1:0] wrId;

   always_comb begin
      activeCnt = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++)
         activeCnt = activeCnt + CW'(dispatchLaneActive_i[k]);
      pushN = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++)
         pushN = pushN + CW'(selValid_i[k]);
      stall     = freeCnt < activeCnt;
      underflow = dispatchReady_i & stall;
      popN      = (dispatchReady_i & ~stall) ? activeCnt : '0;
      // popN never exceeds freeCnt, so the extra bit only catches overflow.
      cntSum    = {1'b0, freeCnt} - {1'b0, popN} + {1'b0, pushN};
      overflow  = cntSum > (CW+1)'(SIZE_ISSUEQ);
   end

   genvar g;
   generate
      for (g = 0; g < DISPATCH_WIDTH; g++) begin : gOffer
         assign freeId_o[g*LOG +: LOG] = idBuf[headPtr + LOG'(g)];
         assign freeValid_o[g]         = CW'(g) < freeCnt;
      end
      for (g = 0; g < ISSUE_WIDTH; g++) begin : gPush
         assign wrId[g] = selId_i[g*LOG +: LOG];
         iq_free_list_push_lane #(
            .SIZE_ISSUEQ_LOG(LOG),
            .ISSUE_WIDTH    (ISSUE_WIDTH),
            .LANE           (g)
         ) uLane (
            .tailPtr (tailPtr),
            .selValid(selValid_i),
            .dropAll (overflow),
            .wrEn    (wrEn[g]),
            .wrAddr  (wrAddr[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SIZE_ISSUEQ; i++)
            idBuf[i] <= LOG'(i);
         headPtr <= '0;
         tailPtr <= '0;
         freeCnt <= CW'(SIZE_ISSUEQ);
         error_o <= 1'b0;
      end else if (flush_i) begin
         // Everything returns to free; the sticky error survives a flush.
         for (int i = 0; i < SIZE_ISSUEQ; i++)
            idBuf[i] <= LOG'(i);
         headPtr <= '0;
         tailPtr <= '0;
         freeCnt <= CW'(SIZE_ISSUEQ);
      end else begin
         headPtr <= headPtr + popN[LOG-1:0];
         if (overflow) begin
            freeCnt <= freeCnt - popN;
         end else begin
            tailPtr <= tailPtr + pushN[LOG-1:0];
            freeCnt <= cntSum[CW-1:0];
         end
         for (int k = 0; k < ISSUE_WIDTH; k++)
            if (wrEn[k]) idBuf[wrAddr[k]] <= wrId[k];
         if (underflow | overflow) error_o <= 1'b1;
      end
   end

   assign freeCnt_o = freeCnt;
   assign iqStall_o = stall;
endmodule
